// File: rtl/robo_pkg.sv
// Shared heading type, grid/counter widths and the left-turn rule for the robo odometry block.
// Optional remove counter is enabled by defining ROBO_REMOVE_CNT_EN.
package robo_pkg;

   typedef enum logic [1:0] {
      N = 2'b00,
      S = 2'b01,
      L = 2'b10,
      O = 2'b11
   } heading_t;

   localparam int ROW_W    = 4;
   localparam int COL_W    = 5;
   localparam int MOVE_W   = 24;
   localparam int REMOVE_W = 8;

   // A left turn walks the compass counter-clockwise: N -> O -> S -> L -> N.
   function automatic heading_t turn_left(input heading_t h);
      heading_t r;
      case (h)
         N:       r = O;
         O:       r = S;
         S:       r = L;
         default: r = N;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/robo_rumo.sv
// Heading register of the robo: holds the current direction and applies left turns.
module robo_rumo
   import robo_pkg::*;
#(
   parameter heading_t START_DIR = N
) (
   input  logic     clock,
   input  logic     reset,
   input  logic     turn_en,
   output heading_t dir
);

   heading_t dir_reg;

   always_ff @(posedge clock) begin
      if (reset) begin
         dir_reg <= START_DIR;
      end else if (turn_en) begin
         dir_reg <= turn_left(dir_reg);
      end
   end

   assign dir = dir_reg;

endmodule

// File: rtl/robo_odometria.sv
// Grid odometry for the robo: tracks position, heading, move budget and sticky error flags.
// Define ROBO_REMOVE_CNT_EN to build the saturating remove counter; otherwise remove_count is 0.
module robo_odometria
   import robo_pkg::*;
#(
   parameter int       ROWS      = 10,
   parameter int       COLS      = 20,
   parameter int       START_ROW = 10,
   parameter int       START_COL = 1,
   parameter heading_t START_DIR = N,
   parameter int       MAX_MOVES = 25
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                forward,
   input  logic                turn,
   input  logic                remove,
   output logic [ROW_W-1:0]    row,
   output logic [COL_W-1:0]    col,
   output logic [1:0]          dir,
   output logic [MOVE_W-1:0]   move_count,
   output logic [REMOVE_W-1:0] remove_count,
   output logic                anomaly,
   output logic                illegal,
   output logic                done
);

   localparam logic [ROW_W-1:0]  ROWS_V      = ROW_W'(ROWS);
   localparam logic [COL_W-1:0]  COLS_V      = COL_W'(COLS);
   localparam logic [MOVE_W-1:0] MAX_MOVES_V = MOVE_W'(MAX_MOVES);

   logic [ROW_W-1:0]  row_reg, row_next;
   logic [COL_W-1:0]  col_reg, col_next;
   logic [MOVE_W-1:0] move_count_reg, move_count_next;
   logic              anomaly_reg, anomaly_next;
   logic              illegal_reg, illegal_next;
   logic              done_reg, done_next;

   logic              accept;
   logic              turn_en;
   logic              frozen;
   logic              at_edge;
   logic [1:0]        cmd_count;
   heading_t          dir_cur;

   robo_rumo #(
      .START_DIR (START_DIR)
   ) u_rumo (
      .clock   (clock),
      .reset   (reset),
      .turn_en (turn_en),
      .dir     (dir_cur)
   );

   assign frozen    = anomaly_reg | illegal_reg | done_reg;
   assign cmd_count = {1'b0, forward} + {1'b0, turn} + {1'b0, remove};

   always_comb begin
      unique case (dir_cur)
         N:       at_edge = (row_reg == ROW_W'(1));
         S:       at_edge = (row_reg == ROWS_V);
         L:       at_edge = (col_reg == COLS_V);
         default: at_edge = (col_reg == COL_W'(1));
      endcase
   end

   always_comb begin
      row_next        = row_reg;
      col_next        = col_reg;
      move_count_next = move_count_reg;
      anomaly_next    = anomaly_reg;
      illegal_next    = illegal_reg;
      done_next       = done_reg;
      accept          = 1'b0;
      turn_en         = 1'b0;

      if (!frozen) begin
         if (cmd_count > 2'd1) begin
            illegal_next = 1'b1;
         end else if (forward) begin
            if (at_edge) begin
               anomaly_next = 1'b1;
            end else begin
               accept = 1'b1;
               unique case (dir_cur)
                  N:       row_next = row_reg - ROW_W'(1);
                  S:       row_next = row_reg + ROW_W'(1);
                  L:       col_next = col_reg + COL_W'(1);
                  default: col_next = col_reg - COL_W'(1);
               endcase
            end
         end else if (turn) begin
            accept  = 1'b1;
            turn_en = 1'b1;
         end else if (remove) begin
            accept = 1'b1;
         end
      end

      // The budget is exhausted by the very command that reaches it.
      if (accept) begin
         move_count_next = move_count_reg + MOVE_W'(1);
         done_next       = (move_count_next == MAX_MOVES_V);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         row_reg        <= ROW_W'(START_ROW);
         col_reg        <= COL_W'(START_COL);
         move_count_reg <= '0;
         anomaly_reg    <= 1'b0;
         illegal_reg    <= 1'b0;
         done_reg       <= 1'b0;
      end else begin
         row_reg        <= row_next;
         col_reg        <= col_next;
         move_count_reg <= move_count_next;
         anomaly_reg    <= anomaly_next;
         illegal_reg    <= illegal_next;
         done_reg       <= done_next;
      end
   end

`ifdef ROBO_REMOVE_CNT_EN
   logic [REMOVE_W-1:0] remove_count_reg;

   always_ff @(posedge clock) begin
      if (reset) begin
         remove_count_reg <= '0;
      end else if (accept && remove && (remove_count_reg != {REMOVE_W{1'b1}})) begin
         remove_count_reg <= remove_count_reg + REMOVE_W'(1);
      end
   end

   assign remove_count = remove_count_reg;
`else
   assign remove_count = '0;
`endif

   assign row        = row_reg;
   assign col        = col_reg;
   assign dir        = dir_cur;
   assign move_count = move_count_reg;
   assign anomaly    = anomaly_reg;
   assign illegal    = illegal_reg;
   assign done       = done_reg;

endmodule

// File: doc/robo_odometria.md
ROBO_ODOMETRIA -- requirements
Module: robo_odometria

Interface
REQ-001 The module SHALL have one clock and one reset: reset is synchronous and active-high. Ports are listed below as name, direction, width, meaning.
REQ-002 clock  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 forward  input  1  Robo command: advance one cell along the current heading.
REQ-005 turn  input  1  Robo command: rotate 90 degrees left, staying in place.
REQ-006 remove  input  1  Robo command: collect debris in the current cell, staying in place.
REQ-007 row  output  4  current row, 1..ROWS; row 1 is the northernmost.
REQ-008 col  output  5  current column, 1..COLS; column 1 is the westernmost.
REQ-009 dir  output  2  heading: N=00, S=01, L=10, O=11.
REQ-010 move_count  output  24  number of accepted commands.
REQ-011 remove_count  output  8  number of accepted remove commands.
REQ-012 anomaly  output  1  sticky flag: a forward command would leave the grid.
REQ-013 illegal  output  1  sticky flag: more than one command was high in the same cycle.
REQ-014 done  output  1  sticky flag: move_count has reached MAX_MOVES.
REQ-015 Parameters are listed as name, default, meaning.
REQ-016 ROWS, 10, grid height.
REQ-017 COLS, 20, grid width.
REQ-018 START_ROW, 10, reset row.
REQ-019 START_COL, 1, reset column.
REQ-020 START_DIR, 2'b00 (N), reset heading.
REQ-021 MAX_MOVES, 25, move budget.

Function
REQ-022 All state SHALL be sampled on the rising clock edge; outputs are registered and reflect a command one cycle after the edge on which it was sampled.
REQ-023 A command SHALL be accepted when exactly one of forward/turn/remove is high and none of anomaly, illegal or done is set.
REQ-024 An accepted command SHALL increment move_count by 1, with no wrap.
REQ-025 An accepted forward SHALL update position by heading: N row-1, S row+1, L col+1, O col-1.
REQ-026 An accepted turn SHALL update heading: N->O, O->S, S->L, L->N; row and col are unchanged.
REQ-027 An accepted remove SHALL increment remove_count, saturating at 255; position and heading are unchanged.
REQ-028 A forward at an edge (N with row=1, S with row=ROWS, L with col=COLS, O with col=1) SHALL leave position unchanged, not count as a move, and set anomaly.
REQ-029 Two or more commands high in the same cycle SHALL set illegal; no state other than illegal changes.
REQ-030 When move_count becomes MAX_MOVES, done SHALL be set in that same update.
REQ-031 Once anomaly, illegal or done is set, all state SHALL freeze until reset.
REQ-032 A cycle with all commands low SHALL change no state.

Reset
REQ-033 While reset=1 at a clock edge: row=START_ROW, col=START_COL, dir=START_DIR, move_count=0, remove_count=0, anomaly=0, illegal=0, done=0.
REQ-034 Reset SHALL take priority over any command sampled on the same edge.
REQ-035 Reset asserted mid-operation SHALL discard all history, including sticky flags.

Configuration
REQ-036 When ROBO_REMOVE_CNT_EN is defined, the remove_count register and its logic SHALL be present.
REQ-037 When ROBO_REMOVE_CNT_EN is undefined, remove_count SHALL be constant 0 with no register; remove still counts as a move.

Structure
REQ-038 A shared package robo_pkg SHALL hold the heading typedef, the N/S/L/O constants and a turn_left function, shared with Robo and its bench.
REQ-039 One sub-module, robo_rumo, SHALL hold the heading register and the turn logic.

Verification
REQ-040 Reset, then forward held for 3 cycles with defaults -> row=7, col=1, dir=N, move_count=3.
REQ-041 Four turn pulses from N -> dir sequence O, S, L, N; move_count=4; position unchanged.
REQ-042 From row=10, heading S, forward -> anomaly=1, row=10, move_count unchanged; further commands are ignored.
REQ-043 forward and remove high together -> illegal=1, all other outputs unchanged.
REQ-044 25 alternating turn/remove commands -> done=1 at move_count=25; a 26th command is ignored; remove_count=12 with ROBO_REMOVE_CNT_EN defined, 0 without.
REQ-045 Reset asserted while done=1 -> all outputs return to reset values the next cycle.
